// File: rtl/nf10_rr_input_arbiter.sv
// Packet-granular round-robin arbiter. It shares one AXI-Stream datapath
// between NUM_QUEUES RX queues and counts forwarded packets per queue.
//
// state | meaning
// IDLE  | no packet owns the datapath; pick the next valid queue after LAST
// PKT   | GRANT owns the datapath until its TLAST beat is accepted
module nf10_rr_input_arbiter #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_QUEUES           = 4,
   parameter int CNT_WIDTH            = 32,
   localparam int GW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
   localparam int DW = C_M_AXIS_DATA_WIDTH,
   localparam int SW = C_M_AXIS_DATA_WIDTH / 8,
   localparam int UW = C_M_AXIS_TUSER_WIDTH
) (
   input  logic                        AXI_ACLK,
   input  logic                        AXI_RESET,
   input  logic [NUM_QUEUES*DW-1:0]    S_AXIS_TDATA,
   input  logic [NUM_QUEUES*SW-1:0]    S_AXIS_TSTRB,
   input  logic [NUM_QUEUES*UW-1:0]    S_AXIS_TUSER,
   input  logic [NUM_QUEUES-1:0]       S_AXIS_TVALID,
   input  logic [NUM_QUEUES-1:0]       S_AXIS_TLAST,
   output logic [NUM_QUEUES-1:0]       S_AXIS_TREADY,
   output logic [DW-1:0]               M_AXIS_TDATA,
   output logic [SW-1:0]               M_AXIS_TSTRB,
   output logic [UW-1:0]               M_AXIS_TUSER,
   output logic                        M_AXIS_TVALID,
   output logic                        M_AXIS_TLAST,
   input  logic                        M_AXIS_TREADY,
   output logic [GW-1:0]               GRANT,
   output logic                        BUSY,
   output logic [NUM_QUEUES*CNT_WIDTH-1:0] PKT_CNT
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PKT  = 1'b1;

   logic [0:0]    state_q;
   logic [GW-1:0] grant_q;
   logic [GW-1:0] last_q;
   logic [GW-1:0] nxt_grant;
   logic          any_valid;
   logic          pkt_end;

   assign BUSY  = (state_q == ST_PKT);
   assign GRANT = grant_q;

   // Round-robin scan starting just after the last served queue.
   always_comb begin
      logic [GW-1:0] idx;
      nxt_grant = last_q;
      any_valid = 1'b0;
      idx       = '0;
      for (int i = 1; i <= NUM_QUEUES; i++) begin
         idx = GW'((int'(last_q) + i) % NUM_QUEUES);
         if (!any_valid && S_AXIS_TVALID[idx]) begin
            any_valid = 1'b1;
            nxt_grant = idx;
         end
      end
   end

   // Combinational datapath mux; valid and ready only open while a packet owns it.
   always_comb begin
      M_AXIS_TDATA  = S_AXIS_TDATA[int'(grant_q)*DW +: DW];
      M_AXIS_TSTRB  = S_AXIS_TSTRB[int'(grant_q)*SW +: SW];
      M_AXIS_TUSER  = S_AXIS_TUSER[int'(grant_q)*UW +: UW];
      M_AXIS_TLAST  = S_AXIS_TLAST[grant_q];
      M_AXIS_TVALID = BUSY & S_AXIS_TVALID[grant_q];
      S_AXIS_TREADY = '0;
      if (BUSY) begin
         S_AXIS_TREADY[grant_q] = M_AXIS_TREADY;
      end
   end

   assign pkt_end = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;

   // Arbitration FSM: one bubble cycle in IDLE per packet, release on TLAST.
   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= GW'(NUM_QUEUES - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_valid) begin
                  grant_q <= nxt_grant;
                  state_q <= ST_PKT;
               end
            end
            default: begin
               if (pkt_end) begin
                  last_q  <= grant_q;
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q;

      // Per-queue forwarded-packet counter, wraps naturally.
      always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
         if (AXI_RESET) begin
            cnt_q <= '0;
         end else if (pkt_end && (grant_q == GW'(i))) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign PKT_CNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
   end

endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Scoreboard bench for nf10_rr_input_arbiter: per-queue source models feed
// directed packets, expected beats are queued in hand-derived order, and a
// negedge monitor pops and compares every accepted output beat.
module tb_nf10_rr_input_arbiter;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = DW / 8;
   localparam int NQ = 4;
   localparam int CW = 32;
   localparam int GW = 2;

   typedef struct { int pkt; int beat; bit last; int gap; } beat_t;
   typedef struct { int q; int pkt; int beat; bit last; } exp_t;

   logic                AXI_ACLK = 1'b0;
   logic                AXI_RESET = 1'b1;
   logic [NQ*DW-1:0]    S_AXIS_TDATA = '0;
   logic [NQ*SW-1:0]    S_AXIS_TSTRB = '0;
   logic [NQ*UW-1:0]    S_AXIS_TUSER = '0;
   logic [NQ-1:0]       S_AXIS_TVALID = '0;
   logic [NQ-1:0]       S_AXIS_TLAST = '0;
   logic [NQ-1:0]       S_AXIS_TREADY;
   logic [DW-1:0]       M_AXIS_TDATA;
   logic [SW-1:0]       M_AXIS_TSTRB;
   logic [UW-1:0]       M_AXIS_TUSER;
   logic                M_AXIS_TVALID;
   logic                M_AXIS_TLAST;
   logic                M_AXIS_TREADY = 1'b1;
   logic [GW-1:0]       GRANT;
   logic                BUSY;
   logic [NQ*CW-1:0]    PKT_CNT;

   nf10_rr_input_arbiter #(
      .C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(UW),
      .NUM_QUEUES(NQ), .CNT_WIDTH(CW)
   ) dut (
      .AXI_ACLK(AXI_ACLK), .AXI_RESET(AXI_RESET),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
      .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TVALID(S_AXIS_TVALID),
      .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
      .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TVALID(M_AXIS_TVALID),
      .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
      .GRANT(GRANT), .BUSY(BUSY), .PKT_CNT(PKT_CNT)
   );

   always #5 AXI_ACLK = ~AXI_ACLK;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge AXI_ACLK) cyc <= cyc + 1;

   beat_t srcq[NQ][$];
   exp_t  expq[$];
   int    startq[$];
   int    endq[$];
   bit    loaded[NQ];
   int    gcnt[NQ];
   bit    hs[NQ];
   logic [CW-1:0] exp_cnt[NQ];
   bit    cnt_pend = 0;
   bit    in_pkt = 0;
   bit    preload_req = 0;
   int    stall_cnt = 0;
   int    stall_badg = 0;

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] mk_d32(input int q, input int pkt, input int beat);
      return {4'hA, 4'(q), 8'(pkt), 8'(beat), 8'h5A};
   endfunction

   // Source models: one beat per queue at a time, optional pre-beat TVALID gap.
   initial begin
      forever begin
         @(negedge AXI_ACLK);
         for (int q = 0; q < NQ; q++) hs[q] = S_AXIS_TVALID[q] & S_AXIS_TREADY[q];
         @(posedge AXI_ACLK);
         #1;
         for (int q = 0; q < NQ; q++) begin
            if (hs[q] && srcq[q].size() > 0) begin
               void'(srcq[q].pop_front());
               loaded[q] = 1'b0;
            end
            if (srcq[q].size() > 0) begin
               if (!loaded[q]) begin
                  gcnt[q] = srcq[q][0].gap;
                  loaded[q] = 1'b1;
               end
               if (gcnt[q] > 0) begin
                  gcnt[q]--;
                  S_AXIS_TVALID[q] = 1'b0;
                  S_AXIS_TLAST[q] = 1'b0;
               end else begin
                  logic [31:0] d;
                  d = mk_d32(q, srcq[q][0].pkt, srcq[q][0].beat);
                  S_AXIS_TDATA[q*DW +: DW] = {8{d}};
                  S_AXIS_TUSER[q*UW +: UW] = {4{~d}};
                  S_AXIS_TSTRB[q*SW +: SW] = d ^ 32'hC3A5_0F96;
                  S_AXIS_TLAST[q] = srcq[q][0].last;
                  S_AXIS_TVALID[q] = 1'b1;
               end
            end else begin
               S_AXIS_TVALID[q] = 1'b0;
               S_AXIS_TLAST[q] = 1'b0;
            end
         end
      end
   end

   // Monitor: scoreboard pops, ready rule, counter model, stall tally.
   always @(negedge AXI_ACLK) begin
      logic [NQ*CW-1:0] cv;
      logic [NQ-1:0]    rdy_req;
      exp_t             e;
      logic [31:0]      d;
      if (AXI_RESET) begin
         for (int q = 0; q < NQ; q++) exp_cnt[q] = '0;
         cnt_pend = 0;
         in_pkt = 0;
      end else begin
         if (preload_req) exp_cnt[0] = '1;
         if (cnt_pend) begin
            for (int q = 0; q < NQ; q++) cv[q*CW +: CW] = exp_cnt[q];
            check("pkt_cnt_model", PKT_CNT, cv);
            cnt_pend = 0;
         end
         rdy_req = '0;
         if (BUSY && M_AXIS_TREADY) rdy_req[GRANT] = 1'b1;
         check("ready_rule", S_AXIS_TREADY, rdy_req);
         if (BUSY && !M_AXIS_TVALID) begin
            stall_cnt++;
            if (GRANT != 0) stall_badg++;
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (!in_pkt) startq.push_back(cyc);
            in_pkt = !M_AXIS_TLAST;
            if (expq.size() == 0) begin
               check("unexpected_beat", {M_AXIS_TLAST, GRANT}, 0);
            end else begin
               e = expq.pop_front();
               d = mk_d32(e.q, e.pkt, e.beat);
               check("beat_data", M_AXIS_TDATA, {8{d}});
               check("beat_user", M_AXIS_TUSER, {4{~d}});
               check("beat_strb", M_AXIS_TSTRB, d ^ 32'hC3A5_0F96);
               check("beat_last_grant", {M_AXIS_TLAST, GRANT}, {e.last, GW'(e.q)});
               if (e.last) begin
                  exp_cnt[e.q] = exp_cnt[e.q] + 1'b1;
                  cnt_pend = 1;
               end
            end
            if (M_AXIS_TLAST) endq.push_back(cyc);
         end
      end
   end

   task automatic add_pkt(input int q, input int pkt, input int nbeats, input int gap_beat, input int gap);
      beat_t b;
      for (int i = 0; i < nbeats; i++) begin
         b.pkt = pkt; b.beat = i; b.last = (i == nbeats - 1);
         b.gap = (i == gap_beat) ? gap : 0;
         srcq[q].push_back(b);
      end
   endtask

   task automatic add_exp(input int q, input int pkt, input int nbeats);
      exp_t e;
      for (int i = 0; i < nbeats; i++) begin
         e.q = q; e.pkt = pkt; e.beat = i; e.last = (i == nbeats - 1);
         expq.push_back(e);
      end
   endtask

   task automatic apply_reset();
      AXI_RESET = 1'b1;
      for (int q = 0; q < NQ; q++) begin
         srcq[q].delete();
         loaded[q] = 1'b0;
         gcnt[q] = 0;
      end
      expq.delete();
      S_AXIS_TVALID = '0;
      S_AXIS_TLAST = '0;
      M_AXIS_TREADY = 1'b1;
      repeat (2) @(posedge AXI_ACLK);
      #2;
      AXI_RESET = 1'b0;
      startq.delete();
      endq.delete();
      stall_cnt = 0;
      stall_badg = 0;
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int n = 0;
      while ((expq.size() != 0 || BUSY) && n < budget) begin
         @(negedge AXI_ACLK);
         n++;
      end
      check(nm, (expq.size() == 0 && !BUSY), 1);
      @(posedge AXI_ACLK);
      #2;
   endtask

   task automatic wait_grant(input string nm, input int g, input int budget);
      int n = 0;
      @(negedge AXI_ACLK);
      while (!(BUSY && GRANT == GW'(g)) && n < budget) begin
         @(negedge AXI_ACLK);
         n++;
      end
      check(nm, (BUSY && GRANT == GW'(g)), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pc;
      logic [DW-1:0] hold;
      logic [3:0] pat;
      pat = 4'b1001;
      hold = '0;

      @(posedge AXI_ACLK);
      #2;
      apply_reset();
      check("reset_outputs", {GRANT, BUSY, M_AXIS_TVALID, S_AXIS_TREADY}, 0);
      check("reset_pkt_cnt", PKT_CNT, 0);

      // 1: lone 3-beat packet on queue 2
      pc = cyc;
      add_pkt(2, 0, 3, -1, 0);
      add_exp(2, 0, 3);
      wait_drain("t1_drain", 40);
      check("t1_first_beat_cycle", (startq.size() > 0) ? startq[0] : -1, pc + 2);
      check("t1_pkt_cnt2", PKT_CNT[2*CW +: CW], 1);
      check("t1_idle", {BUSY, M_AXIS_TVALID, S_AXIS_TREADY}, 0);

      // 2: all queues continuously valid, 2-beat packets
      apply_reset();
      for (int p = 0; p < 2; p++)
         for (int q = 0; q < NQ; q++) begin
            add_pkt(q, p, 2, -1, 0);
            add_exp(q, p, 2);
         end
      wait_drain("t2_drain", 100);
      check("t2_pkt_count", endq.size(), 8);
      for (int i = 1; i < endq.size(); i++) check("t2_pkt_spacing", endq[i] - endq[i-1], 3);
      for (int q = 0; q < NQ; q++) check("t2_pkt_cnt", PKT_CNT[q*CW +: CW], 2);

      // 3: downstream stall mid-packet on queue 1, queue 3 waiting
      apply_reset();
      add_pkt(1, 0, 4, -1, 0);
      add_pkt(3, 0, 1, -1, 0);
      add_exp(1, 0, 4);
      add_exp(3, 0, 1);
      wait_grant("t3_grant1", 1, 20);
      for (int i = 0; i < 4; i++) begin
         @(posedge AXI_ACLK);
         #2;
         M_AXIS_TREADY = pat[3-i];
         @(negedge AXI_ACLK);
         check("t3_ready_mirror", S_AXIS_TREADY, {2'b00, pat[3-i], 1'b0});
         if (i == 1) hold = M_AXIS_TDATA;
         if (i == 2) check("t3_data_stable", M_AXIS_TDATA, hold);
      end
      @(posedge AXI_ACLK);
      #2;
      M_AXIS_TREADY = 1'b1;
      wait_drain("t3_drain", 40);
      check("t3_pkt_cnt", {PKT_CNT[1*CW +: CW], PKT_CNT[3*CW +: CW]}, {32'd1, 32'd1});

      // 4: queue 0 source stall of 5 cycles while queue 3 waits
      apply_reset();
      add_pkt(0, 0, 3, 1, 5);
      add_pkt(3, 0, 1, -1, 0);
      add_exp(0, 0, 3);
      add_exp(3, 0, 1);
      wait_drain("t4_drain", 60);
      check("t4_stall_cycles", stall_cnt, 5);
      check("t4_stall_grant_moved", stall_badg, 0);

      // 5: back-to-back single-beat packets on queue 1
      apply_reset();
      for (int p = 0; p < 4; p++) begin
         add_pkt(1, p, 1, -1, 0);
         add_exp(1, p, 1);
      end
      wait_drain("t5_drain", 40);
      check("t5_pkt_count", endq.size(), 4);
      for (int i = 1; i < endq.size(); i++) check("t5_pkt_spacing", endq[i] - endq[i-1], 2);
      check("t5_pkt_cnt1", PKT_CNT[1*CW +: CW], 4);

      // 6a: counter wrap on queue 0
      apply_reset();
      force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
      preload_req = 1;
      @(negedge AXI_ACLK);
      @(posedge AXI_ACLK);
      #2;
      release dut.g_cnt[0].cnt_q;
      preload_req = 0;
      add_pkt(0, 0, 2, -1, 0);
      add_exp(0, 0, 2);
      wait_drain("t6a_drain", 40);
      check("t6a_wrap", PKT_CNT[0 +: CW], 0);

      // 6b: reset in the middle of a queue 2 packet
      add_pkt(1, 1, 1, -1, 0);
      add_pkt(2, 1, 4, -1, 0);
      add_exp(1, 1, 1);
      add_exp(2, 1, 4);
      wait_grant("t6b_grant2", 2, 20);
      @(posedge AXI_ACLK);
      #2;
      check("t6b_cnt1_before", PKT_CNT[1*CW +: CW], 1);
      AXI_RESET = 1'b1;
      #1;
      check("t6b_reset_ctl", {BUSY, M_AXIS_TVALID, S_AXIS_TREADY, GRANT}, 0);
      check("t6b_reset_cnt", PKT_CNT, 0);
      apply_reset();
      repeat (3) @(negedge AXI_ACLK);
      check("t6b_after_reset", {BUSY, M_AXIS_TVALID}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
